wb_farbborg_loader: RTL and testbench

- Wishbone initiator that copies a frame of 32-bit words from system memory into the farbborg PWM frame-buffer window.
- Started by a CPU-side control strobe; reads each word from the source, then writes it to the destination.
- Sits on the shared Wishbone interconnect beside the CPU, so a full 2048-entry frame loads without per-pixel CPU writes.

---
 rtl/wb_farbborg_pkg.sv | 19 +
 rtl/wb_ack_timeout.sv | 38 +++
 rtl/wb_farbborg_loader.sv | 197 +++++++++++++++++++
 tb/tb_wb_farbborg_loader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/wb_farbborg_pkg.sv
// Shared constants for the farbborg frame loader: state encoding and bus constants.
package wb_farbborg_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RD   = 2'd1;
  localparam state_t S_WR   = 2'd2;
  localparam state_t S_FIN  = 2'd3;

  localparam logic [3:0]  WB_SEL_ALL  = 4'hF;
  localparam logic [31:0] WORD_STRIDE = 32'd4;
  localparam logic [31:0] WORD_MASK   = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/wb_ack_timeout.sv
// Per-access acknowledge watchdog: down-counter reloaded on clear, expired at zero.
module wb_ack_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Loading TIMEOUT-1 makes the access last exactly TIMEOUT cycles before abort.
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/wb_farbborg_loader.sv
// Wishbone initiator copying a block of 32-bit words from memory into the farbborg
// frame buffer, one read then one write per word inside a single locked cycle.
module wb_farbborg_loader
  import wb_farbborg_pkg::*;
#(
  parameter int          LEN_W       = 12,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] DST_DEFAULT = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic             dst_sel,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  output logic [3:0]       wb_sel_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  input  logic             wb_ack_i
);

  // state  | meaning
  // IDLE   | waiting for start
  // RD     | read of current source word outstanding
  // WR     | write of captured word to destination outstanding
  // FIN    | copy over; next edge pulses done and drops busy

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [31:0]      src_inc;
  logic [31:0]      dst_inc;
  logic             to_clear;
  logic             to_en;
  logic             to_expired;

  assign src_inc = src_q + WORD_STRIDE;
  assign dst_inc = dst_q + WORD_STRIDE;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        // done_q high means FIN was just left; a start in that cycle is dropped.
        if (start && !done_q) begin
          src_d  = word_align(src_addr);
          dst_d  = dst_sel ? word_align(dst_addr) : word_align(DST_DEFAULT);
          rem_d  = len;
          err_d  = 1'b0;
          busy_d = 1'b1;
          if (len == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RD;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            adr_d   = word_align(src_addr);
          end
        end
      end

      S_RD: begin
        if (wb_ack_i) begin
          dat_d   = wb_dat_i;
          we_d    = 1'b1;
          adr_d   = dst_q;
          state_d = S_WR;
        end else if (to_expired) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end

      S_WR: begin
        if (wb_ack_i) begin
          rem_d = rem_q - LEN_W'(1);
          src_d = src_inc;
          dst_d = dst_inc;
          we_d  = 1'b0;
          if (rem_q == LEN_W'(1)) begin
            cyc_d   = 1'b0;
            state_d = S_FIN;
          end else begin
            adr_d   = src_inc;
            state_d = S_RD;
          end
        end else if (to_expired) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    sel_d = cyc_d ? WB_SEL_ALL : 4'h0;
  end

  // Every entry into RD or WR is a state change, so the watchdog restarts per access.
  assign to_clear = (state_d != state_q);
  assign to_en    = (state_q == S_RD) || (state_q == S_WR);

  wb_ack_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_ack_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (to_clear),
    .en_i     (to_en),
    .expired_o(to_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;

endmodule

// File: tb/tb_wb_farbborg_loader.sv
// Randomized self-checking bench for wb_farbborg_loader against a word-copy reference model.
module tb_wb_farbborg_loader;

  localparam int          TO      = 255;
  localparam logic [31:0] DST_DEF = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic        dst_sel;
  logic [11:0] len;
  logic        busy, done, err;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic        ack_en;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_farbborg_loader #(
    .LEN_W      (12),
    .TIMEOUT    (TO),
    .DST_DEFAULT(DST_DEF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .dst_sel (dst_sel),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_we_o (wb_we_o),
    .wb_ack_i(wb_ack_i)
  );

  // Source memory contents as a pure function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'h0000_00A1;
      32'h0000_1004: return 32'h0000_00B2;
      32'h0000_1008: return 32'h0000_00C3;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign wb_dat_i = mem_word(wb_adr_o);
  assign wb_ack_i = ack_en && wb_cyc_o && wb_stb_o;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One copy: stall >= 0 withholds ack on that read index; glitch re-pulses start while busy
  // and again in the done cycle.
  task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input logic sel,
                         input int n, input int stall, input bit glitch, input string tag);
    logic [31:0] s_eff, d_eff, ea;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] ra[$];
    int lat, busy_n, done_n, cyc_rise, stall_cyc, bus_bad, exp_w, exp_lat;
    bit seen_done, prev_cyc, ack_now;
    s_eff   = s & 32'hFFFF_FFFC;
    d_eff   = (sel ? d : DST_DEF) & 32'hFFFF_FFFC;
    exp_w   = (stall < 0) ? n : stall;
    exp_lat = (stall < 0) ? 2 * n + 2 : 2 * stall + 2 + TO;
    lat = 0; busy_n = 0; done_n = 0; cyc_rise = 0; stall_cyc = 0; bus_bad = 0;
    seen_done = 0; prev_cyc = 0;

    @(posedge clk); #1;
    src_addr = s; dst_addr = d; dst_sel = sel; len = 12'(n); start = 1'b1; ack_en = 1'b1;
    for (int c = 0; c < exp_lat + 40 && !seen_done; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        start = 1'b0;
        src_addr = $urandom; dst_addr = $urandom; dst_sel = 1'($urandom); len = 12'($urandom);
      end
      if (glitch && c == 2) begin
        start = 1'b1; src_addr = 32'h4444_0000; dst_addr = 32'h5555_0000; len = 12'd7;
      end
      if (glitch && c == 3) start = 1'b0;
      lat++;
      ack_en  = !(stall >= 0 && !wb_we_o && ra.size() == stall);
      ack_now = ack_en && wb_cyc_o && wb_stb_o;
      if (wb_cyc_o && !wb_we_o && stall >= 0 && ra.size() == stall) stall_cyc++;
      if (ack_now && !wb_we_o) ra.push_back(wb_adr_o);
      if (ack_now && wb_we_o) begin
        wa.push_back(wb_adr_o);
        wd.push_back(wb_dat_o);
      end
      if (wb_cyc_o && !prev_cyc) cyc_rise++;
      prev_cyc = wb_cyc_o;
      if (wb_cyc_o && (wb_sel_o != 4'hF || !wb_stb_o)) bus_bad++;
      if (!wb_cyc_o && (wb_sel_o != 4'h0 || wb_stb_o || wb_we_o)) bus_bad++;
      if (busy) busy_n++;
      if (done) begin
        seen_done = 1;
        done_n++;
      end
    end
    ack_en = 1'b1;
    check({tag, "_done_seen"}, 64'(seen_done), 64'd1);
    if (glitch) begin
      start = 1'b1; src_addr = 32'h6666_0000; len = 12'd5;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    check({tag, "_idle_after"}, {62'd0, busy, wb_cyc_o}, 64'd0);

    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
    check({tag, "_err"}, 64'(err), 64'(stall >= 0));
    check({tag, "_cyc_rises"}, 64'(cyc_rise), 64'(n > 0));
    check({tag, "_bus_sig"}, 64'(bus_bad), 64'd0);
    if (stall >= 0) check({tag, "_stall_len"}, 64'(stall_cyc), 64'(TO));
    check({tag, "_n_reads"}, 64'(ra.size()), 64'(exp_w));
    check({tag, "_n_writes"}, 64'(wa.size()), 64'(exp_w));
    for (int i = 0; i < exp_w && i < wa.size() && i < ra.size(); i++) begin
      ea = s_eff + 32'(4 * i);
      check({tag, "_rd_adr"}, 64'(ra[i]), 64'(ea));
      check({tag, "_wr_dat"}, 64'(wd[i]), 64'(mem_word(ea)));
      ea = d_eff + 32'(4 * i);
      check({tag, "_wr_adr"}, 64'(wa[i]), 64'(ea));
    end
  endtask

  initial begin
    bit found;
    int nw;
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; dst_sel = 1'b0; len = '0;
    ack_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {61'd0, busy, done, err}, 64'd0);
    check("rst_bus", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o}, 64'd0);
    check("rst_dat", 64'(wb_dat_o), 64'd0);
    reset = 1'b0;

    do_copy(32'h0000_1000, 32'h0000_8000, 1'b1, 3, -1, 1'b0, "len3");
    do_copy(32'h0000_1000, 32'h0000_8000, 1'b1, 0, -1, 1'b0, "len0");
    do_copy(32'h0000_2000, 32'h0000_9000, 1'b1, 3, 1, 1'b0, "timeout");
    do_copy(32'h0000_3000, 32'h0000_A000, 1'b1, 4, -1, 1'b1, "busy_start");
    do_copy(32'hFFFF_FFFC, 32'h0000_0100, 1'b1, 2, -1, 1'b0, "wrap");

    // Reset during the write of the second word of a four-word copy.
    @(posedge clk); #1;
    src_addr = 32'h0000_2000; dst_addr = 32'h0000_9000; dst_sel = 1'b1; len = 12'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0; nw = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (wb_cyc_o && wb_we_o) begin
        if (nw == 1) found = 1;
        else nw++;
      end
      if (!found) begin
        @(posedge clk); #1;
      end
    end
    check("rst_mid_found", 64'(found), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_bus", {61'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 64'd0);
    check("rst_mid_ctrl", {61'd0, busy, done, err}, 64'd0);
    check("rst_mid_sel", 64'(wb_sel_o), 64'd0);
    reset = 1'b0;
    do_copy(32'h0000_1004, 32'h0000_C000, 1'b0, 1, -1, 1'b0, "after_rst");

    for (int k = 0; k < 8; k++) begin
      do_copy($urandom, $urandom, 1'($urandom), int'($urandom_range(1, 6)), -1, 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
